sha_digest_axis_tx: RTL

SHA_DIGEST_AXIS_TX -- requirements
Module: sha_digest_axis_tx

---
 rtl/sha_digest_axis_tx.sv | 137 +++++++++++++
 1 files changed

// File: rtl/sha_digest_axis_tx.sv
// Streams a captured Keccak state (digest or full state) as 16-bit AXI-Stream words.
// Define SHA_DIGEST_TX_FULL_STATE_EN to enable Mode=0 full 1600-bit state transmission.
module sha_digest_axis_tx #(
  parameter int WIDTH = 16
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic [1599:0]    state_i,
  input  logic             start_i,
  input  logic [1:0]       USER,
  input  logic             Mode,
  output logic             ready_o,
  input  logic             TREADY,
  output logic             TVALID_o,
  output logic [WIDTH-1:0] TDATA_o,
  output logic             TLAST_o,
  output logic             TKEEP_o,
  output logic             TSTRB_o,
  output logic [1:0]       TID_o,
  output logic             TDEST_o,
  output logic [3:0]       TUSER_o
);

`ifdef SHA_DIGEST_TX_FULL_STATE_EN
  localparam int CAP_BITS = 1600;
`else
  localparam int CAP_BITS = 512;
`endif
  localparam int BYTES = WIDTH / 8;

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_reg;
  logic [CAP_BITS-1:0] cap_reg;
  logic [6:0]          cnt_reg;
  logic [6:0]          last_idx_reg;
  logic [WIDTH-1:0]    data_reg;
  logic                valid_reg;
  logic                last_reg;
  logic [1:0]          tid_reg;
  logic                mode_reg;

  logic [CAP_BITS-1:0] state_cap;
  logic [WIDTH-1:0]    first_word;
  logic [WIDTH-1:0]    next_word;
  logic [6:0]          last_idx_next;
  logic                mode_next;

  assign state_cap = state_i[CAP_BITS-1:0];

`ifndef SHA_DIGEST_TX_FULL_STATE_EN
  logic unused_inputs;
  assign unused_inputs = &{1'b0, Mode, state_i[1599:CAP_BITS]};
`endif

  // Lower-addressed byte goes to the most significant lane of the word.
  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_word
      assign first_word[WIDTH-1-8*gi -: 8] = state_cap[8*gi +: 8];
      assign next_word[WIDTH-1-8*gi -: 8]  = cap_reg[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    last_idx_next = 7'd13;
    case (USER)
      2'd0: last_idx_next = 7'd13;
      2'd1: last_idx_next = 7'd15;
      2'd2: last_idx_next = 7'd23;
      2'd3: last_idx_next = 7'd31;
      default: last_idx_next = 7'd13;
    endcase
`ifdef SHA_DIGEST_TX_FULL_STATE_EN
    mode_next = Mode;
    if (!Mode) last_idx_next = 7'd99;
`else
    mode_next = 1'b1;
`endif
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_reg    <= IDLE;
      cap_reg      <= '0;
      cnt_reg      <= '0;
      last_idx_reg <= '0;
      data_reg     <= '0;
      valid_reg    <= 1'b0;
      last_reg     <= 1'b0;
      tid_reg      <= '0;
      mode_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            // Word 0 is presented straight from the input; the remainder is kept pre-shifted.
            cap_reg      <= state_cap >> WIDTH;
            data_reg     <= first_word;
            cnt_reg      <= '0;
            last_idx_reg <= last_idx_next;
            last_reg     <= 1'b0;
            tid_reg      <= USER;
            mode_reg     <= mode_next;
            valid_reg    <= 1'b1;
            state_reg    <= SEND;
          end
        end
        SEND: begin
          if (TREADY) begin
            if (last_reg) begin
              valid_reg <= 1'b0;
              last_reg  <= 1'b0;
              state_reg <= IDLE;
            end else begin
              data_reg <= next_word;
              cap_reg  <= cap_reg >> WIDTH;
              cnt_reg  <= cnt_reg + 7'd1;
              last_reg <= ((cnt_reg + 7'd1) == last_idx_reg);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ready_o  = (state_reg == IDLE);
  assign TVALID_o = valid_reg;
  assign TDATA_o  = data_reg;
  assign TLAST_o  = last_reg;
  assign TKEEP_o  = valid_reg;
  assign TSTRB_o  = valid_reg;
  assign TID_o    = tid_reg;
  assign TDEST_o  = 1'b0;
  assign TUSER_o  = {1'b0, mode_reg, tid_reg};

endmodule
